// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions: sequencer state encoding and the jump-select
// polarity constant used on the jump_n wire.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    READY  = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  // jump_n is active-low: this level means "take the branch".
  localparam logic JUMP_TAKE = 1'b0;

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Next-PC calculator: branch target or PC+1, wrapping modulo 2^ADDR_W.
module pc_next
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              jump_n_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              take_o
);

  assign take_o    = (jump_n_i == JUMP_TAKE);
  // Plain ADDR_W-bit add drops the carry, giving the required wrap.
  assign next_pc_o = take_o ? target_i : pc_i + ADDR_W'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches over req/ack, presents instr to execute,
// advances or branches on retire, counts retirements and supports halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_n,
  input  logic [ADDR_W-1:0]  target,
  input  logic               step,
  input  logic               halt,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               branch_taken,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  pc_state_e          state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               req_q;
  logic               valid_q;
  logic               bt_q;
  logic               halted_q;
  logic [CNT_W-1:0]   retired_q;

  logic [ADDR_W-1:0]  pc_d;
  logic               take_d;

  pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc_i      (pc_q),
    .target_i  (target),
    .jump_n_i  (jump_n),
    .next_pc_o (pc_d),
    .take_o    (take_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      req_q     <= 1'b1;
      valid_q   <= 1'b0;
      bt_q      <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      bt_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_data;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= READY;
          end
        end
        READY: begin
          // Halt wins over a coincident step; that step is simply lost.
          if (halt) begin
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= HALTED;
          end else if (step) begin
            retired_q <= retired_q + CNT_W'(1);
            pc_q      <= pc_d;
            bt_q      <= take_d;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
            state_q   <= FETCH;
          end
        end
        HALTED: begin
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign imem_req     = req_q;
  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign pc           = pc_q;
  assign branch_taken = bt_q;
  assign halted       = halted_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer with a transaction-level model.
module tb_pc_sequencer;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 4;
  localparam int NCYC    = 3000;

  localparam int K_FETCH = 0, K_RETIRE = 1, K_HALT = 2, K_RESET = 3;
  localparam int P_FETCH = 0, P_READY = 1, P_HALTED = 2;

  typedef struct {
    int kind;
    int pc;
    int instr;
    int ret;
    int bt;
  } item_t;

  item_t sbq[$];

  logic               clk = 1'b0;
  logic               rst;
  logic               jump_n;
  logic [ADDR_W-1:0]  target;
  logic               step;
  logic               halt;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_req;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               branch_taken;
  logic               halted;
  logic [CNT_W-1:0]   retired;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .jump_n(jump_n), .target(target), .step(step),
    .halt(halt), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .branch_taken(branch_taken),
    .halted(halted), .retired(retired)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic item_t mk(int k, int p, int i, int r, int b);
    item_t it;
    it.kind = k; it.pc = p; it.instr = i; it.ret = r; it.bt = b;
    return it;
  endfunction

  // Directed opening: jump 05, fall to 06, jump 40, jump FF, wrap to 00.
  int jn_tab [5] = '{0, 1, 0, 0, 1};
  int tg_tab [5] = '{8'h05, 8'h00, 8'h40, 8'hFF, 8'h00};

  // Monitor: pops the scoreboard whenever the DUT shows a transition.
  initial begin : monitor
    item_t it;
    int m_phase, m_pc, m_ret, m_instr;
    logic prev_valid, prev_halted, prev_req;
    logic ev_fetch, ev_retire, ev_halt, ev_reset;
    m_phase = P_FETCH; m_pc = 0; m_ret = 0; m_instr = 0;
    prev_valid = 1'b0; prev_halted = 1'b0; prev_req = 1'b1;
    forever begin
      @(negedge clk);
      if (!started) continue;
      ev_fetch  = instr_valid && !prev_valid;
      ev_retire = imem_req && !prev_req && prev_valid;
      ev_halt   = halted && !prev_halted;
      ev_reset  = !halted && prev_halted;
      if (ev_fetch || ev_retire || ev_halt || ev_reset) begin
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_empty: DUT transition with no expected item at %0t", $time);
        end else begin
          it = sbq.pop_front();
          if (ev_fetch) begin
            chk("fetch_kind", K_FETCH, it.kind);
            chk("fetch_instr", instr, it.instr);
            m_instr = it.instr; m_phase = P_READY;
          end else if (ev_retire) begin
            chk("retire_kind", K_RETIRE, it.kind);
            chk("retire_bt", branch_taken, it.bt);
            m_phase = P_FETCH;
          end else if (ev_halt) begin
            chk("halt_kind", K_HALT, it.kind);
            m_phase = P_HALTED;
          end else begin
            chk("reset_kind", K_RESET, it.kind);
            m_phase = P_FETCH;
          end
          m_pc = it.pc; m_ret = it.ret;
        end
      end
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("retired", retired, m_ret);
      chk("imem_req", imem_req, m_phase == P_FETCH);
      chk("instr_valid", instr_valid, m_phase == P_READY);
      chk("halted", halted, m_phase == P_HALTED);
      if (m_phase == P_READY) chk("instr_hold", instr, m_instr);
      if (!ev_retire) chk("bt_idle", branch_taken, 1'b0);
      prev_valid = instr_valid; prev_halted = halted; prev_req = imem_req;
    end
  end

  // Driver plus behavioural model (phase, pc, retire count).
  int ph, nph, mpc, mret, wait_cnt, delay, fcount, dir_i, hold_cnt, jn, tg;
  bit rand_mode;

  initial begin : driver
    rst = 1'b1; jump_n = 1'b1; target = '0; step = 1'b0; halt = 1'b0;
    imem_ack = 1'b0; imem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_req", imem_req, 1);
    chk("rst_instr", instr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_bt", branch_taken, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    rst = 1'b0;
    started = 1'b1;
    ph = P_FETCH; mpc = 0; mret = 0; wait_cnt = 0; delay = 1;
    fcount = 0; dir_i = 0; hold_cnt = 0; rand_mode = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      nph = ph;
      rst = 1'b0; step = 1'b0; imem_ack = 1'b0;
      imem_data = INSTR_W'($urandom);
      jn = int'($urandom_range(0, 1)); tg = int'($urandom_range(0, 255));
      jump_n = jn[0]; target = tg[7:0];
      if (rand_mode && !halt && ph != P_HALTED && $urandom_range(0, 39) == 0) halt = 1'b1;
      case (ph)
        P_FETCH: begin
          step = ($urandom_range(0, 3) == 0);
          if (!rand_mode && dir_i == 5) halt = 1'b1;
          if (wait_cnt == delay) begin
            imem_ack = 1'b1;
            if (fcount == 0) imem_data = 16'hA5A5;
            sbq.push_back(mk(K_FETCH, mpc, int'(imem_data), mret, 0));
            fcount++;
            nph = P_READY;
          end else begin
            wait_cnt++;
          end
        end
        P_READY: begin
          imem_ack = ($urandom_range(0, 3) == 0);
          if (!rand_mode) begin
            step = 1'b1;
            if (dir_i < 5) begin
              jn = jn_tab[dir_i]; tg = tg_tab[dir_i];
              jump_n = jn[0]; target = tg[7:0];
            end
          end else begin
            step = $urandom_range(0, 1) == 1;
          end
          if (halt) begin
            sbq.push_back(mk(K_HALT, mpc, 0, mret, 0));
            hold_cnt = int'($urandom_range(1, 4));
            nph = P_HALTED;
          end else if (step) begin
            mpc  = (jn == 0) ? tg : (mpc + 1) % 256;
            mret = (mret + 1) % 16;
            sbq.push_back(mk(K_RETIRE, mpc, 0, mret, (jn == 0) ? 1 : 0));
            if (!rand_mode) dir_i++;
            wait_cnt = 0;
            delay = (!rand_mode && dir_i == 5) ? 4 : int'($urandom_range(0, 5));
            nph = P_FETCH;
          end
        end
        default: begin
          step = $urandom_range(0, 1) == 1;
          imem_ack = $urandom_range(0, 1) == 1;
          if (hold_cnt == 0) begin
            rst = 1'b1; halt = 1'b0;
            mpc = 0; mret = 0; wait_cnt = 0;
            delay = int'($urandom_range(0, 5));
            sbq.push_back(mk(K_RESET, 0, 0, 0, 0));
            rand_mode = 1'b1;
            nph = P_FETCH;
          end else begin
            hold_cnt--;
          end
        end
      endcase
      @(posedge clk);
      #1;
      ph = nph;
    end

    rst = 1'b0; step = 1'b0; imem_ack = 1'b0; halt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
